mem_access_unit: RTL and testbench

Byte-serial memory access unit directly downstream of the reorder buffer's commit port. Accepts one committed load/store from the ROB head, executes it over the 8-bit RAM/IO bus one byte per cycle, then returns a single-cycle completion pulse, with load data, to the ROB. One access in flight at a time. Accesses are in program order because the ROB only issues its head entry.

---
 rtl/mem_access_unit.sv | 163 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Byte-serial load/store executor between the ROB commit port and the 8-bit RAM/IO bus.
// Optional macro MEM_ACCESS_IO_STALL_EN: IO stores wait in WAIT_IO until io_buffer_full clears.
module mem_access_unit #(
   parameter int OPW = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           rdy,
   input  logic           flush,
   input  logic           lsb_enable,
   input  logic [5:0]     lsb_rob_index,
   input  logic [OPW-1:0] lsb_opcode,
   input  logic [31:0]    lsb_ls_addr,
   input  logic [31:0]    lsb_s_val,
   output logic           lsb_ls_enable,
   output logic [5:0]     lsb_rob_index_out,
   output logic [31:0]    lsb_l_data,
   input  logic [7:0]     mem_din,
   output logic [7:0]     mem_dout,
   output logic [31:0]    mem_a,
   output logic           mem_wr,
   input  logic           io_buffer_full,
   output logic           busy
);
   localparam logic [OPW-1:0] LB  = OPW'(1);
   localparam logic [OPW-1:0] LH  = OPW'(2);
   localparam logic [OPW-1:0] LW  = OPW'(3);
   localparam logic [OPW-1:0] LBU = OPW'(4);
   localparam logic [OPW-1:0] LHU = OPW'(5);
   localparam logic [OPW-1:0] SH  = OPW'(7);
   localparam logic [OPW-1:0] SW  = OPW'(8);

   typedef enum logic [1:0] {IDLE, LOAD, STORE, WAIT_IO} state_t;

   state_t         state_q;
   logic [OPW-1:0] op_q;
   logic [5:0]     tag_q;
   logic [31:0]    addr_q, sdat_q, lbuf_q;
   logic [1:0]     cnt_q;
   logic           flushed_q;

   logic [2:0]  n;
   logic        more;
   logic [1:0]  cnt_nx;
   logic [31:0] nxt_a, ld_raw, ld_ext;
   logic [7:0]  nxt_b;
   logic        req_load;

   always_comb begin
      if (op_q == LW || op_q == SW)                    n = 3'd4;
      else if (op_q == LH || op_q == LHU || op_q == SH) n = 3'd2;
      else                                             n = 3'd1;
      cnt_nx = cnt_q + 2'd1;
      more   = ({1'b0, cnt_q} + 3'd1) < n;
      nxt_a  = addr_q + {30'd0, cnt_nx};
      nxt_b  = sdat_q[{cnt_nx, 3'b000} +: 8];
      // the final byte is still on mem_din, so merge it before extending
      ld_raw = lbuf_q;
      ld_raw[{cnt_q, 3'b000} +: 8] = mem_din;
      case (op_q)
         LB:      ld_ext = {{24{ld_raw[7]}}, ld_raw[7:0]};
         LH:      ld_ext = {{16{ld_raw[15]}}, ld_raw[15:0]};
         LBU:     ld_ext = {24'd0, ld_raw[7:0]};
         LHU:     ld_ext = {16'd0, ld_raw[15:0]};
         default: ld_ext = ld_raw;
      endcase
      req_load = (lsb_opcode >= LB) && (lsb_opcode <= LHU);
   end

   assign busy = (state_q != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q           <= IDLE;
         op_q              <= '0;
         tag_q             <= '0;
         addr_q            <= '0;
         sdat_q            <= '0;
         lbuf_q            <= '0;
         cnt_q             <= '0;
         flushed_q         <= 1'b0;
         lsb_ls_enable     <= 1'b0;
         lsb_rob_index_out <= '0;
         lsb_l_data        <= '0;
         mem_a             <= '0;
         mem_dout          <= '0;
         mem_wr            <= 1'b0;
      end else if (rdy) begin
         lsb_ls_enable <= 1'b0;
         case (state_q)
            IDLE: if (lsb_enable && !flush) begin
               op_q      <= lsb_opcode;
               tag_q     <= lsb_rob_index;
               addr_q    <= lsb_ls_addr;
               sdat_q    <= lsb_s_val;
               lbuf_q    <= '0;
               cnt_q     <= '0;
               flushed_q <= 1'b0;
               if (req_load) begin
                  state_q <= LOAD;
                  mem_a   <= lsb_ls_addr;
                  mem_wr  <= 1'b0;
               end
`ifdef MEM_ACCESS_IO_STALL_EN
               else if (lsb_ls_addr[17:16] == 2'b11) begin
                  state_q <= WAIT_IO;
                  mem_wr  <= 1'b0;
               end
`endif
               else begin
                  state_q  <= STORE;
                  mem_a    <= lsb_ls_addr;
                  mem_dout <= lsb_s_val[7:0];
                  mem_wr   <= 1'b1;
               end
            end
            LOAD: if (flush) begin
               state_q <= IDLE;
               mem_wr  <= 1'b0;
            end else begin
               lbuf_q <= ld_raw;
               cnt_q  <= cnt_nx;
               if (more) mem_a <= nxt_a;
               else begin
                  state_q           <= IDLE;
                  lsb_ls_enable     <= 1'b1;
                  lsb_rob_index_out <= tag_q;
                  lsb_l_data        <= ld_ext;
               end
            end
            STORE: begin
               // a committed store always drains; flush only hides its completion
               cnt_q <= cnt_nx;
               if (flush) flushed_q <= 1'b1;
               if (more) begin
                  mem_a    <= nxt_a;
                  mem_dout <= nxt_b;
                  mem_wr   <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  mem_wr  <= 1'b0;
                  if (!(flushed_q || flush)) begin
                     lsb_ls_enable     <= 1'b1;
                     lsb_rob_index_out <= tag_q;
                     lsb_l_data        <= '0;
                  end
               end
            end
            WAIT_IO: begin
               if (flush) flushed_q <= 1'b1;
               if (!io_buffer_full) begin
                  state_q  <= STORE;
                  cnt_q    <= '0;
                  mem_a    <= addr_q;
                  mem_dout <= sdat_q[7:0];
                  mem_wr   <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit with a per-transaction behavioural model.
module tb_mem_access_unit;
   localparam logic [5:0] LB = 6'd1, LH = 6'd2, LW = 6'd3, LBU = 6'd4, LHU = 6'd5,
                          SB = 6'd6, SH = 6'd7, SW = 6'd8;
`ifdef MEM_ACCESS_IO_STALL_EN
   localparam bit IO_STALL = 1'b1;
`else
   localparam bit IO_STALL = 1'b0;
`endif

   logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1, flush = 1'b0;
   logic        lsb_enable = 1'b0, io_buffer_full = 1'b0;
   logic [5:0]  lsb_rob_index = '0, lsb_opcode = '0;
   logic [31:0] lsb_ls_addr = '0, lsb_s_val = '0;
   logic        lsb_ls_enable, mem_wr, busy;
   logic [5:0]  lsb_rob_index_out;
   logic [31:0] lsb_l_data, mem_a;
   logic [7:0]  mem_din, mem_dout;
   logic [7:0]  ram [0:1023];
   int total = 0, bad = 0;

   assign mem_din = ram[mem_a[9:0]];
   always #5 clk = ~clk;

   mem_access_unit #(.OPW(6)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .lsb_enable(lsb_enable), .lsb_rob_index(lsb_rob_index), .lsb_opcode(lsb_opcode),
      .lsb_ls_addr(lsb_ls_addr), .lsb_s_val(lsb_s_val),
      .lsb_ls_enable(lsb_ls_enable), .lsb_rob_index_out(lsb_rob_index_out), .lsb_l_data(lsb_l_data),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full), .busy(busy)
   );

   // One transaction, entered and left on a falling edge. flush_at/hold_at count edges after accept.
   task automatic access(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sval,
                         input logic [5:0] tag, input int stall, input int flush_at,
                         input int hold_at, input string name);
      int n, lat, pulses, pulse_k, last_k, eff, exp_last;
      bit is_ld, is_io, done, exp_pulse;
      logic [31:0] exp_data, got_data, ai;
      logic [5:0] got_tag;
      logic [31:0] wa[$];
      logic [7:0] wd[$];
      n = (op == LW || op == SW) ? 4 : (op == LH || op == LHU || op == SH) ? 2 : 1;
      is_ld = (op <= LHU);
      is_io = !is_ld && (addr[17:16] == 2'b11) && IO_STALL;
      lat = n + (is_io ? 1 + stall : 0) + (hold_at > 0 ? 2 : 0);
      exp_data = 0;
      if (is_ld) begin
         for (int i = 0; i < n; i++) begin
            ai = addr + 32'(i);
            exp_data = exp_data + (32'(ram[ai[9:0]]) << (8 * i));
         end
         if (op == LB) exp_data = 32'($signed(exp_data[7:0]));
         if (op == LH) exp_data = 32'($signed(exp_data[15:0]));
      end
      exp_pulse = (flush_at < 0);
      exp_last = (is_ld && flush_at >= 0) ? flush_at : lat;

      lsb_enable = 1'b1; lsb_opcode = op; lsb_ls_addr = addr; lsb_s_val = sval;
      lsb_rob_index = tag; io_buffer_full = (stall > 0); flush = 1'b0; rdy = 1'b1;
      @(posedge clk);
      pulses = 0; pulse_k = -1; last_k = -1; done = 0; got_data = 0; got_tag = 0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         eff = k;
         if (hold_at > 0) eff = k - ((k >= hold_at) ? 1 : 0) - ((k >= hold_at + 1) ? 1 : 0);
         if (mem_wr && !(hold_at > 0 && (k == hold_at || k == hold_at + 1))) begin
            wa.push_back(mem_a); wd.push_back(mem_dout);
         end
         if (k == 0) begin
            total++;
            if (busy !== 1'b1 || lsb_ls_enable !== 1'b0) begin
               bad++; $display("FAIL %s accept: busy=%b pulse=%b, need busy=1 pulse=0", name, busy, lsb_ls_enable);
            end
         end
         if (is_ld && flush_at < 0 && eff < n) begin
            total++;
            if (mem_a !== addr + 32'(eff) || mem_wr !== 1'b0) begin
               bad++; $display("FAIL %s rd_addr k=%0d: got %h wr=%b, need %h wr=0", name, k, mem_a, mem_wr, addr + 32'(eff));
            end
         end
         if (lsb_ls_enable) begin
            pulses++;
            if (pulse_k < 0) begin pulse_k = k; got_data = lsb_l_data; got_tag = lsb_rob_index_out; end
         end
         if (k > 0 && !busy) begin done = 1; last_k = k; end
         lsb_enable = 1'b0;
         io_buffer_full = (k + 1 <= stall);
         flush = (k + 1 == flush_at);
         rdy = !(hold_at > 0 && (k + 1 == hold_at || k + 1 == hold_at + 1));
      end
      flush = 1'b0; io_buffer_full = 1'b0; rdy = 1'b1;

      total++;
      if (!done || last_k != exp_last) begin
         bad++; $display("FAIL %s finish: idle at edge %0d (done=%0d), need %0d", name, last_k, done, exp_last);
      end
      total++;
      if (pulses != int'(exp_pulse)) begin
         bad++; $display("FAIL %s pulses: got %0d, need %0d", name, pulses, int'(exp_pulse));
      end
      if (exp_pulse) begin
         total++;
         if (pulse_k != lat || got_data !== (is_ld ? exp_data : 32'd0) || got_tag !== tag) begin
            bad++; $display("FAIL %s result: k=%0d data=%h tag=%0d, need k=%0d data=%h tag=%0d",
                            name, pulse_k, got_data, got_tag, lat, is_ld ? exp_data : 32'd0, tag);
         end
      end
      total++;
      if (wa.size() != (is_ld ? 0 : n)) begin
         bad++; $display("FAIL %s write_count: got %0d, need %0d", name, wa.size(), is_ld ? 0 : n);
      end else if (!is_ld) begin
         for (int i = 0; i < n; i++) begin
            total++;
            if (wa[i] !== addr + 32'(i) || wd[i] !== sval[8*i +: 8]) begin
               bad++; $display("FAIL %s write%0d: got (%h,%h), need (%h,%h)", name, i, wa[i], wd[i],
                               addr + 32'(i), sval[8*i +: 8]);
            end
         end
      end
   endtask

   task automatic test_reset();
      #1;
      total++;
      if (lsb_ls_enable !== 1'b0 || lsb_rob_index_out !== 6'd0 || lsb_l_data !== 32'd0 ||
          mem_a !== 32'd0 || mem_dout !== 8'd0 || mem_wr !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL reset: pulse=%b tag=%0d data=%h a=%h dout=%h wr=%b busy=%b, need all 0",
                         lsb_ls_enable, lsb_rob_index_out, lsb_l_data, mem_a, mem_dout, mem_wr, busy);
      end
   endtask

   task automatic test_load();
      ram[10'h100] = 8'h78; ram[10'h101] = 8'h56; ram[10'h102] = 8'h34; ram[10'h103] = 8'h12;
      access(LW, 32'h100, 32'h0, 6'd5, 0, -1, 0, "lw_0x100");
      total++;
      if (lsb_l_data !== 32'h12345678) begin
         bad++; $display("FAIL lw_value: got %h, need 12345678", lsb_l_data);
      end
   endtask

   task automatic test_sign();
      ram[10'h040] = 8'h80; ram[10'h050] = 8'h34; ram[10'h051] = 8'hF2;
      access(LB, 32'h40, 32'h0, 6'd1, 0, -1, 0, "lb_80");
      total++;
      if (lsb_l_data !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_value: got %h, need ffffff80", lsb_l_data); end
      access(LBU, 32'h40, 32'h0, 6'd2, 0, -1, 0, "lbu_80");
      total++;
      if (lsb_l_data !== 32'h00000080) begin bad++; $display("FAIL lbu_value: got %h, need 00000080", lsb_l_data); end
      access(LH, 32'h50, 32'h0, 6'd3, 0, -1, 0, "lh_f234");
      total++;
      if (lsb_l_data !== 32'hFFFFF234) begin bad++; $display("FAIL lh_value: got %h, need fffff234", lsb_l_data); end
   endtask

   task automatic test_store();
      access(SH, 32'h201, 32'hABCD, 6'd4, 0, -1, 0, "sh_0x201");
      access(SB, 32'h30000, 32'h41, 6'd6, 3, -1, 0, "sb_io_stall");
   endtask

   task automatic test_flush();
      access(LW, 32'h100, 32'h0, 6'd7, 0, 1, 0, "lw_flush");
      access(LB, 32'h40, 32'h0, 6'd8, 0, -1, 0, "lb_after_flush");
      access(SW, 32'h300, 32'hDEADBEEF, 6'd9, 0, 2, 0, "sw_flush");
   endtask

   task automatic test_rdy_hold();
      access(LW, 32'h104, 32'h0, 6'd10, 0, -1, 2, "lw_rdy_hold");
   endtask

   task automatic test_back_to_back();
      access(LW, 32'hFFFF_FFFE, 32'h0, 6'd11, 0, -1, 0, "b2b_lw_wrap");
      access(SB, 32'h10, 32'h5A, 6'd12, 0, -1, 0, "b2b_sb");
      access(LHU, 32'h3FF, 32'h0, 6'd13, 0, -1, 0, "b2b_lhu");
   endtask

   task automatic test_reset_mid();
      bit wr_seen;
      lsb_enable = 1'b1; lsb_opcode = SW; lsb_ls_addr = 32'h500; lsb_s_val = 32'h01020304;
      lsb_rob_index = 6'd14;
      @(posedge clk);
      @(negedge clk);
      lsb_enable = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      total++;
      if (mem_wr !== 1'b0 || busy !== 1'b0 || mem_a !== 32'd0 || lsb_ls_enable !== 1'b0) begin
         bad++; $display("FAIL reset_mid: wr=%b busy=%b a=%h pulse=%b, need all 0", mem_wr, busy, mem_a, lsb_ls_enable);
      end
      @(negedge clk);
      rst = 1'b1;
      wr_seen = 0;
      repeat (6) begin @(negedge clk); if (mem_wr || busy || lsb_ls_enable) wr_seen = 1; end
      total++;
      if (wr_seen) begin bad++; $display("FAIL reset_resume: activity after reset=1, need none"); end
   endtask

   task automatic test_random();
      logic [5:0] op;
      logic [31:0] addr;
      int stall, fl;
      for (int t = 0; t < 40; t++) begin
         op = 6'(LB + $urandom_range(0, 7));
         addr = $urandom;
         if ($urandom_range(0, 3) == 0) addr[17:16] = 2'b11;
         if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
         stall = (op >= SB && addr[17:16] == 2'b11) ? $urandom_range(0, 3) : 0;
         fl = ($urandom_range(0, 7) == 0) ? 1 : -1;
         access(op, addr, $urandom, 6'($urandom), stall, fl, 0, "random");
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
      rst = 1'b0;
      #12;
      test_reset();
      rst = 1'b1;
      @(negedge clk);
      test_load();
      test_sign();
      test_store();
      test_flush();
      test_rdy_hold();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
